hamming_secded_enc_stream: RTL and testbench
============================================

# hamming_secded_enc_stream

Streaming, parametrised SECDED Hamming encoder for the UART datapath. It generalises the fixed 4-bit Hamming(8,4) encoding to any data width `DATA_W`. Words are accepted on a valid/ready input, encoded, and buffered in a small output FIFO that presents a valid/ready codeword stream to the transmitter framing logic. Optional per-word error injection (single or double bit flip) lets the downstream decoder and link be exercised in-system. Pop and injection counters are provided for status.

## Interface
- `DATA_W`, 8: payload width, 1..57.
- `DEPTH`, 2: output FIFO depth, power of two, ≥2.
- `CNT_W`, 16: width of status counters.
- Derived: `PAR_W` is the smallest r with 2^r ≥ DATA_W+r+1; `CODE_W` = DATA_W+PAR_W+1.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  DATA_W  payload.
- `inj_single`  in  1  flip one code bit of this word; sampled with the input handshake.
- `inj_double`  in  1  flip two code bits of this word; takes priority over `inj_single`.
- `inj_pos`  in  $clog2(CODE_W)  first flipped bit index; values ≥CODE_W are taken modulo CODE_W.
- `out_valid`  out  1  codeword at FIFO head.
- `out_ready`  in  1  consumer takes the codeword.
- `out_code`  out  CODE_W  head codeword.
- `pop_count`  out  CNT_W  codewords delivered, wraps.
- `inj_count`  out  CNT_W  words accepted with any injection, wraps.

## Operation
- Code layout:
  - `out_code[i]`, i = 1..CODE_W-1, holds Hamming position i.
  - Parity bits sit at power-of-two positions. Parity at 2^k is the XOR of all data positions whose index has bit k set.
  - Data bits fill the non-power-of-two positions in ascending order, with `in_data[0]` at position 3.
  - `out_code[0]` is the overall parity: XOR of bits 1..CODE_W-1, so every clean codeword has even weight.
- Injection:
  - Flips are applied after encoding, before the FIFO write.
  - Single: flips bit p = `inj_pos` mod CODE_W.
  - Double: flips bits p and (p+1) mod CODE_W.
  - `inj_count` increments on an accepted word with either injection flag high.
- FIFO:
  - Push when `in_valid && in_ready`.
  - Pop when `out_valid && out_ready`.
  - `in_ready` = not full. There is no pass-through when full, even if a pop occurs in the same cycle.
  - `out_valid` = not empty.
  - Simultaneous push and pop while neither full nor empty: occupancy is unchanged, and both pointers advance and wrap modulo DEPTH.
- Counters: `pop_count` increments on each pop. Both counters wrap from 2^CNT_W-1 to 0.
- Inputs outside a handshake are ignored, including injection flags.

## Timing
- Reset values:
  - FIFO empty, pointers 0.
  - `in_ready`=1, `out_valid`=0, `out_code`=0.
  - `pop_count`=`inj_count`=0.
  - Storage cleared.
- Latency: a word accepted at edge N appears with `out_valid`=1 in the cycle after edge N, given the FIFO was empty.
- `out_code` is stable while `out_valid && !out_ready`.
- Throughput is one word per cycle while the consumer keeps `out_ready` high.
- After DEPTH unpopped pushes, `in_ready` falls in the cycle after the filling edge. It rises in the cycle after the first pop.
- `rst` asserted mid-stream empties the FIFO immediately, independent of the clock. Buffered words are discarded and no partial state survives.
- The encoder is combinational between the input and the FIFO write, so there is no extra pipeline stage.

## Structure
- Package `hamming_pkg` holds:
  - functions `f_par_w(data_w)`, `f_code_w(data_w)`, `f_is_pow2(pos)`;
  - function `f_secded_encode` (generic loop over positions), reused by the planned matching decoder.
- One sub-module, `hamming_secded_enc_core`: combinational encoder, parameter DATA_W, data in, codeword out.
- FIFO, injection and counters stay in the top module.

## Test plan
- DATA_W=4, no injection, `out_ready`=1:
  - `in_data`=4'hB → `out_code`=8'hAA one cycle later.
  - 4'h0 → 8'h00.
  - 4'hF → 8'hFF.
  - `pop_count`=3 afterwards.
- Backpressure, DATA_W=4, DEPTH=2, `out_ready`=0:
  - Push 4'h1, 4'h2 → `in_ready`=0 after the second push; a third `in_valid` is not accepted.
  - Raise `out_ready` → codes emerge in order, with `in_ready` back to 1 after the first pop.
- Single injection: 4'hB with `inj_single`=1, `inj_pos`=1 → 8'hA8, `inj_count`=1.
- Double injection wrap: 4'hB with `inj_double`=1, `inj_pos`=7 → 8'h2B (bits 7 and 0 flipped), `inj_count`=1.
- DATA_W=8, CODE_W=13: 256 random words, each decoded by the reference model → syndrome 0, overall parity even, data recovered. Random `out_ready` throughout, with no loss or reordering.
- Reset mid-operation: FIFO full, assert `rst` between clock edges → `out_valid`=0 and `in_ready`=1 immediately, counters 0. The next push yields a correct codeword.

Source files
------------

// File: rtl/hamming_pkg.sv
// SECDED Hamming helpers shared by the streaming encoder and the matching decoder.
// All codeword math is done at a fixed 64-bit width so one function serves every DATA_W.
package hamming_pkg;

    localparam int MAX_CODE_W = 64;

    function automatic int f_par_w(input int data_w);
        int r;
        r = 1;
        for (int i = 0; i < 7; i++) begin
            if ((1 << r) < data_w + r + 1) r = r + 1;
        end
        return r;
    endfunction

    function automatic int f_code_w(input int data_w);
        return data_w + f_par_w(data_w) + 1;
    endfunction

    function automatic logic f_is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Position 0 holds overall parity; position i (i>=1) is Hamming position i.
    function automatic logic [MAX_CODE_W-1:0] f_secded_encode(input logic [MAX_CODE_W-1:0] data,
                                                              input int data_w);
        logic [MAX_CODE_W-1:0] code;
        int code_w;
        int d;
        int p;
        code_w = f_code_w(data_w);
        code   = '0;
        d      = 0;
        for (int pos = 3; pos < MAX_CODE_W; pos++) begin
            if (pos < code_w && !f_is_pow2(pos)) begin
                code[pos[5:0]] = data[d[5:0]];
                d = d + 1;
            end
        end
        for (int k = 0; k < 6; k++) begin
            p = 1 << k;
            for (int pos = 3; pos < MAX_CODE_W; pos++) begin
                if (pos < code_w && !f_is_pow2(pos) && ((pos & p) != 0)) begin
                    code[p[5:0]] = code[p[5:0]] ^ code[pos[5:0]];
                end
            end
        end
        code[0] = ^code[MAX_CODE_W-1:1];
        return code;
    endfunction

endpackage

// File: rtl/hamming_secded_enc_core.sv
// Combinational SECDED encoder: payload in, full codeword out.
// Latency: zero cycles (pure logic).
// Backpressure: none; flow control lives in the enclosing stream block.
module hamming_secded_enc_core
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int CODE_W = f_code_w(DATA_W)
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [CODE_W-1:0] o_code
);

    assign o_code = CODE_W'(f_secded_encode(MAX_CODE_W'(i_data), DATA_W));

endmodule

// File: rtl/hamming_secded_enc_stream.sv
// Streaming SECDED encoder with optional bit-flip injection, output FIFO and status counters.
// Latency: word accepted at edge N is valid at the FIFO head the cycle after N.
// Backpressure: in_ready is simply not-full; a same-cycle pop does not free a slot for a push.
module hamming_secded_enc_stream
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 2,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = f_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1,
    localparam int POS_W  = $clog2(CODE_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inj_single,
    input  logic              inj_double,
    input  logic [POS_W-1:0]  inj_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [CNT_W-1:0]  pop_count,
    output logic [CNT_W-1:0]  inj_count
);

    localparam int AW = $clog2(DEPTH);

    logic [CODE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_occ;
    logic [CNT_W-1:0]  r_pop_count;
    logic [CNT_W-1:0]  r_inj_count;

    logic [CODE_W-1:0] w_enc_code;
    logic [CODE_W-1:0] w_flip_mask;
    logic [CODE_W-1:0] w_wr_code;
    logic [POS_W-1:0]  w_p0;
    logic [POS_W-1:0]  w_p1;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    hamming_secded_enc_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .i_data (in_data),
        .o_code (w_enc_code)
    );

    // Out-of-range positions fold back into the codeword; the double flip wraps past the top bit.
    assign w_p0 = POS_W'((32'(inj_pos)) % 32'(CODE_W));
    assign w_p1 = (w_p0 == POS_W'(CODE_W - 1)) ? '0 : w_p0 + POS_W'(1);

    always_comb begin
        w_flip_mask = '0;
        if (inj_double) begin
            w_flip_mask = (CODE_W'(1) << w_p0) | (CODE_W'(1) << w_p1);
        end else if (inj_single) begin
            w_flip_mask = CODE_W'(1) << w_p0;
        end
    end

    assign w_wr_code = w_enc_code ^ w_flip_mask;

    assign w_full  = (r_occ == (AW+1)'(DEPTH));
    assign w_empty = (r_occ == '0);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = !w_empty && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_wr_code;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + (AW+1)'(1);
                2'b01:   r_occ <= r_occ - (AW+1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pop_count <= '0;
            r_inj_count <= '0;
        end else begin
            if (w_pop) begin
                r_pop_count <= r_pop_count + CNT_W'(1);
            end
            if (w_push && (inj_single || inj_double)) begin
                r_inj_count <= r_inj_count + CNT_W'(1);
            end
        end
    end

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_code  = r_mem[r_rd_ptr];
    assign pop_count = r_pop_count;
    assign inj_count = r_inj_count;

endmodule

// File: tb/tb_hamming_secded_enc_stream.sv
// Directed bench: 4-bit encoder vectors, backpressure, injection, reset; 8-bit randomised stream.
module tb_hamming_secded_enc_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid4 = 1'b0, in_ready4, inj_single4 = 1'b0, inj_double4 = 1'b0;
    logic [3:0]  in_data4 = '0;
    logic [2:0]  inj_pos4 = '0;
    logic        out_valid4, out_ready4 = 1'b0;
    logic [7:0]  out_code4;
    logic [15:0] pop_count4, inj_count4;

    logic        in_valid8 = 1'b0, in_ready8, inj_single8 = 1'b0, inj_double8 = 1'b0;
    logic [7:0]  in_data8 = '0;
    logic [3:0]  inj_pos8 = '0;
    logic        out_valid8, out_ready8 = 1'b0;
    logic [12:0] out_code8;
    logic [15:0] pop_count8, inj_count8;

    hamming_secded_enc_stream #(.DATA_W(4), .DEPTH(2), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .inj_single(inj_single4), .inj_double(inj_double4), .inj_pos(inj_pos4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_code(out_code4),
        .pop_count(pop_count4), .inj_count(inj_count4)
    );

    hamming_secded_enc_stream #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .inj_single(inj_single8), .inj_double(inj_double8), .inj_pos(inj_pos8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_code(out_code8),
        .pop_count(pop_count8), .inj_count(inj_count8)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic push4(input logic [3:0] d, input logic s, input logic dd, input logic [2:0] p);
        in_valid4   = 1'b1;
        in_data4    = d;
        inj_single4 = s;
        inj_double4 = dd;
        inj_pos4    = p;
        @(posedge clk); #1;
        in_valid4   = 1'b0;
        inj_single4 = 1'b0;
        inj_double4 = 1'b0;
    endtask

    task automatic pop4();
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
    endtask

    function automatic int syn8(input logic [12:0] c);
        int s;
        s = 0;
        for (int i = 1; i < 13; i++) begin
            if (c[i[3:0]]) s = s ^ i;
        end
        return s;
    endfunction

    function automatic logic [7:0] dat8(input logic [12:0] c);
        logic [7:0] r;
        int d;
        r = '0;
        d = 0;
        for (int i = 3; i < 13; i++) begin
            if ((i & (i - 1)) != 0) begin
                r[d[2:0]] = c[i[3:0]];
                d++;
            end
        end
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0]  sb[$];
    logic [7:0]  exp8;
    logic [12:0] c8;
    logic        acc;
    int          sent, got, cyc;

    initial begin
        #12;
        chk("rst_out_valid", 64'(out_valid4), 64'h0);
        chk("rst_in_ready",  64'(in_ready4),  64'h1);
        chk("rst_out_code",  64'(out_code4),  64'h0);
        chk("rst_pop_count", 64'(pop_count4), 64'h0);
        chk("rst_inj_count", 64'(inj_count4), 64'h0);
        chk("rst_out_valid8", 64'(out_valid8), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic vectors with the consumer always ready.
        out_ready4 = 1'b1;
        push4(4'hB, 1'b0, 1'b0, 3'd0);
        chk("enc_b_valid", 64'(out_valid4), 64'h1);
        chk("enc_b",       64'(out_code4),  64'hAA);
        push4(4'h0, 1'b0, 1'b0, 3'd0);
        chk("enc_0",       64'(out_code4),  64'h00);
        push4(4'hF, 1'b0, 1'b0, 3'd0);
        chk("enc_f",       64'(out_code4),  64'hFF);
        @(posedge clk); #1;
        chk("pop_count_3", 64'(pop_count4), 64'd3);
        chk("drained",     64'(out_valid4), 64'h0);

        // Backpressure with a two-deep FIFO.
        out_ready4 = 1'b0;
        push4(4'h1, 1'b0, 1'b0, 3'd0);
        chk("bp_code1",    64'(out_code4),  64'h0F);
        chk("bp_rdy1",     64'(in_ready4),  64'h1);
        push4(4'h2, 1'b0, 1'b0, 3'd0);
        chk("bp_full",     64'(in_ready4),  64'h0);
        chk("bp_stable",   64'(out_code4),  64'h0F);
        in_valid4 = 1'b1;
        in_data4  = 4'h3;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        chk("bp_still_full", 64'(in_ready4), 64'h0);
        chk("bp_head_held",  64'(out_code4), 64'h0F);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        chk("bp_rdy_back", 64'(in_ready4),  64'h1);
        chk("bp_code2",    64'(out_code4),  64'h33);
        @(posedge clk); #1;
        chk("bp_no_third", 64'(out_valid4), 64'h0);
        chk("bp_pop_cnt",  64'(pop_count4), 64'd5);
        out_ready4 = 1'b0;

        // Injection flags without a handshake must be ignored.
        inj_single4 = 1'b1;
        inj_double4 = 1'b1;
        @(posedge clk); #1;
        inj_single4 = 1'b0;
        inj_double4 = 1'b0;
        chk("inj_idle_cnt", 64'(inj_count4), 64'd0);

        push4(4'hB, 1'b1, 1'b0, 3'd1);
        chk("inj_single",     64'(out_code4),  64'hA8);
        chk("inj_single_cnt", 64'(inj_count4), 64'd1);
        pop4();
        push4(4'hB, 1'b1, 1'b1, 3'd7);
        chk("inj_double_wrap", 64'(out_code4),  64'h2B);
        chk("inj_double_cnt",  64'(inj_count4), 64'd2);
        pop4();
        push4(4'hB, 1'b0, 1'b1, 3'd3);
        chk("inj_double_mid",  64'(out_code4),  64'hB2);
        chk("inj_cnt_3",       64'(inj_count4), 64'd3);
        pop4();

        // Randomised 8-bit stream, checked by an independent decoder.
        sent = 0;
        got  = 0;
        cyc  = 0;
        in_valid8  = 1'b1;
        in_data8   = 8'($urandom);
        out_ready8 = 1'($urandom_range(0, 1));
        while (got < 256 && cyc < 5000) begin
            @(negedge clk);
            if (out_valid8 && out_ready8) begin
                c8 = out_code8;
                if (sb.size() == 0) begin
                    chk("rand_unexpected_pop", 64'h1, 64'h0);
                end else begin
                    exp8 = sb.pop_front();
                    chk("rand_syndrome", 64'(syn8(c8)), 64'h0);
                    chk("rand_parity",   64'(^c8),      64'h0);
                    chk("rand_data",     64'(dat8(c8)), 64'(exp8));
                end
                got++;
            end
            acc = in_valid8 && in_ready8;
            if (acc) begin
                sb.push_back(in_data8);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc || !in_valid8) begin
                in_valid8 = (sent < 256) && ($urandom_range(0, 3) != 0);
                in_data8  = 8'($urandom);
            end
            out_ready8 = ($urandom_range(0, 2) != 0);
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b0;
        chk("rand_received", 64'(got),        64'd256);
        chk("rand_pop_cnt",  64'(pop_count8), 64'd256);
        chk("rand_empty",    64'(out_valid8), 64'h0);

        // Asynchronous reset while the FIFO is full.
        push4(4'h1, 1'b1, 1'b0, 3'd2);
        push4(4'h2, 1'b0, 1'b0, 3'd0);
        chk("mid_full", 64'(in_ready4), 64'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid4), 64'h0);
        chk("mid_rst_ready", 64'(in_ready4),  64'h1);
        chk("mid_rst_code",  64'(out_code4),  64'h0);
        chk("mid_rst_pops",  64'(pop_count4), 64'h0);
        chk("mid_rst_injs",  64'(inj_count4), 64'h0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push4(4'hB, 1'b0, 1'b0, 3'd0);
        chk("post_rst_code",  64'(out_code4),  64'hAA);
        chk("post_rst_valid", 64'(out_valid4), 64'h1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
